// File: rtl/apb_master.sv
// apb_master: command-to-APB bridge (cmd_* request in, APB PSEL/PENABLE/PWRITE/PADDR/PWDATA out, PRDATA/PREADY/PSLVERR in, rsp_* one-cycle completion out) with wait-state timeout
module apb_master #(
  parameter int AWIDTH  = 4,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic tmo, done;
  always_comb begin
    tmo = cnt == CW'(TIMEOUT);
    done = state == ACCESS && (PREADY || tmo);
    cmd_ready = state == IDLE;
    state_n = state == IDLE ? (cmd_valid ? SETUP : IDLE) : state == SETUP ? ACCESS : done ? IDLE : ACCESS;
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      cnt       <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      PSEL      <= state_n != IDLE;
      PENABLE   <= state_n == ACCESS;
      rsp_valid <= done;
      cnt       <= state == ACCESS ? cnt + 1'b1 : '0;
      if (state == IDLE && cmd_valid) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
      end
      if (done) begin
        rsp_err   <= !PREADY || PSLVERR;
        rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
      end
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized self-checking bench against a transaction-level APB master model
module tb_apb_master;
  localparam int TO = 15;
  logic PCLK = 0, PRESETn = 0;
  logic cmd_valid = 0, cmd_write = 0, cmd_ready;
  logic [3:0] cmd_addr = 0, PADDR;
  logic [7:0] cmd_wdata = 0, PWDATA, PRDATA = 0, rsp_rdata;
  logic rsp_valid, rsp_err, PSEL, PENABLE, PWRITE;
  logic PREADY = 0, PSLVERR = 0;
  int vectors = 0, errors = 0;
  apb_master #(.AWIDTH(4), .DWIDTH(8), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );
  always #5 PCLK = ~PCLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic txn(input logic wr, input logic [3:0] a, input logic [7:0] d, input int waits,
                     input logic se, input logic [7:0] rd, input bit hold);
    int n, exp_n;
    bit done, rdy, tmo;
    tmo = waits > TO;
    exp_n = (tmo ? TO : waits) + 1;
    chk("idle_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(posedge PCLK); #1;
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_ready", cmd_ready, 0);
    chk("setup_rsp", rsp_valid, 0);
    chk("setup_paddr", PADDR, a);
    chk("setup_pwrite", PWRITE, wr);
    chk("setup_pwdata", PWDATA, d);
    cmd_valid = hold ? 1'b1 : 1'($urandom); cmd_write = 1'($urandom);
    cmd_addr = 4'($urandom); cmd_wdata = 8'($urandom);
    PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = 8'($urandom);
    n = 0; done = 0;
    while (!done && n <= TO + 3) begin
      @(posedge PCLK); #1;
      if (rsp_valid) done = 1;
      else begin
        chk("acc_psel", PSEL, 1);
        chk("acc_penable", PENABLE, 1);
        chk("acc_ready", cmd_ready, 0);
        chk("acc_paddr", PADDR, a);
        chk("acc_pwrite", PWRITE, wr);
        chk("acc_pwdata", PWDATA, d);
        rdy = n == waits;
        n++;
        PREADY = rdy;
        PSLVERR = rdy ? se : 1'($urandom);
        PRDATA = rdy ? rd : 8'($urandom);
        cmd_valid = hold ? 1'b1 : 1'($urandom); cmd_write = 1'($urandom);
        cmd_addr = 4'($urandom); cmd_wdata = 8'($urandom);
      end
    end
    chk("completed", done, 1);
    chk("acc_cycles", n, exp_n);
    chk("rsp_err", rsp_err, tmo ? 1'b1 : se);
    chk("rsp_rdata", rsp_rdata, (tmo || wr) ? 8'h00 : rd);
    chk("end_psel", PSEL, 0);
    chk("end_penable", PENABLE, 0);
    cmd_valid = hold; PREADY = 1'($urandom);
  endtask
  task automatic gap(input logic [7:0] rd, input logic er, input logic [3:0] a);
    cmd_valid = 0;
    @(posedge PCLK); #1;
    chk("gap_rsp", rsp_valid, 0);
    chk("gap_hold_rdata", rsp_rdata, rd);
    chk("gap_hold_err", rsp_err, er);
    chk("gap_paddr", PADDR, a);
    chk("gap_psel", PSEL, 0);
  endtask
  initial begin
    cmd_valid = 1;
    #3;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_rsp", rsp_valid, 0);
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_no_accept", PSEL, 0);
    cmd_valid = 0;
    #2 PRESETn = 1;
    @(posedge PCLK); #1;
    txn(1, 4'h3, 8'hA5, 0, 0, 8'h77, 0);
    gap(8'h00, 0, 4'h3);
    txn(0, 4'h6, 8'h11, 2, 0, 8'h5C, 0);
    gap(8'h5C, 0, 4'h6);
    txn(0, 4'h9, 8'h22, 0, 1, 8'h33, 0);
    gap(8'h33, 1, 4'h9);
    txn(0, 4'hC, 8'h44, TO + 5, 0, 8'h99, 0);
    gap(8'h00, 1, 4'hC);
    txn(1, 4'h1, 8'h10, 0, 0, 8'h00, 1);
    txn(0, 4'h2, 8'h20, 1, 0, 8'hB7, 1);
    txn(1, 4'h4, 8'h30, 0, 1, 8'h00, 1);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'hE; cmd_wdata = 8'h5A;
    @(posedge PCLK); #1;
    PREADY = 0;
    @(posedge PCLK); #1;
    chk("mid_psel_before", PSEL, 1);
    #2 PRESETn = 0;
    #1;
    chk("mid_psel", PSEL, 0);
    chk("mid_penable", PENABLE, 0);
    chk("mid_paddr", PADDR, 0);
    chk("mid_pwdata", PWDATA, 0);
    chk("mid_ready", cmd_ready, 1);
    repeat (2) begin
      @(posedge PCLK); #1;
      chk("mid_no_rsp", rsp_valid, 0);
      chk("mid_psel_held", PSEL, 0);
    end
    cmd_valid = 0;
    #2 PRESETn = 1;
    @(posedge PCLK); #1;
    chk("post_rst_rsp", rsp_valid, 0);
    txn(0, 4'h7, 8'h00, 1, 0, 8'hC3, 0);
    gap(8'hC3, 0, 4'h7);
    for (int i = 0; i < 150; i++) begin
      logic wr, se;
      logic [3:0] a;
      logic [7:0] d, rd;
      int w;
      wr = 1'($urandom); se = 1'($urandom); a = 4'($urandom);
      d = 8'($urandom); rd = 8'($urandom);
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(0, 4);
      txn(wr, a, d, w, se, rd, 0);
      if ($urandom_range(0, 1) == 1) gap((w > TO || wr) ? 8'h00 : rd, w > TO ? 1'b1 : se, a);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter AWIDTH, default 4, APB address width.
REQ-002 SHALL have parameter DWIDTH, default 8, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum wait-state count in ACCESS before abort; legal range is 1 or greater.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports named PCLK and PRESETn.
REQ-005 SHALL have port PCLK, input, 1 bit, clock; all state SHALL update on the rising edge.
REQ-006 SHALL have port PRESETn, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port cmd_valid, input, 1 bit, command request.
REQ-008 SHALL have port cmd_ready, output, 1 bit, command accept.
REQ-009 SHALL have port cmd_write, input, 1 bit, 1 = write and 0 = read.
REQ-010 SHALL have port cmd_addr, input, AWIDTH bits, target address.
REQ-011 SHALL have port cmd_wdata, input, DWIDTH bits, write data.
REQ-012 SHALL have port rsp_valid, output, 1 bit, single-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata, output, DWIDTH bits, read result.
REQ-014 SHALL have port rsp_err, output, 1 bit, slave error or timeout.
REQ-015 SHALL have ports PSEL, PENABLE and PWRITE, each output, 1 bit, APB control.
REQ-016 SHALL have port PADDR, output, AWIDTH bits; port PWDATA, output, DWIDTH bits.
REQ-017 SHALL have port PRDATA, input, DWIDTH bits; ports PREADY and PSLVERR, each input, 1 bit.

Function
REQ-018 SHALL implement an FSM with states IDLE, SETUP and ACCESS.
REQ-019 SHALL drive cmd_ready = 1 in IDLE only, as a combinational decode of state.
REQ-020 SHALL accept a command when cmd_valid and cmd_ready are both 1 at a clock edge, and then:
- register cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA;
- enter SETUP.
REQ-021 In SETUP, SHALL drive PSEL=1 and PENABLE=0, and unconditionally enter ACCESS on the next edge.
REQ-022 In ACCESS, SHALL drive PSEL=1 and PENABLE=1.
REQ-023 SHALL hold PADDR, PWRITE and PWDATA stable from SETUP to the end of ACCESS, and retain the last values in IDLE.
REQ-024 SHALL clear the wait counter on entry to ACCESS; counter width is clog2(TIMEOUT+1).
REQ-025 In ACCESS with PREADY=1, at the edge the block SHALL:
- return to IDLE;
- pulse rsp_valid for the next cycle;
- set rsp_err = PSLVERR;
- set rsp_rdata = PRDATA for a read, 0 for a write.
REQ-026 In ACCESS with PREADY=0 and counter < TIMEOUT, SHALL increment the counter and remain in ACCESS.
REQ-027 In ACCESS with PREADY=0 and counter == TIMEOUT, SHALL abort to IDLE and pulse rsp_valid with rsp_err=1 and rsp_rdata=0; the transfer occupies at most TIMEOUT+1 ACCESS cycles.
REQ-028 SHALL sample PSLVERR and PRDATA only in ACCESS while PREADY=1, and ignore them otherwise.
REQ-029 SHALL hold rsp_rdata and rsp_err until the next completion; they are meaningful only while rsp_valid=1.
REQ-030 SHALL drive PSEL, PENABLE, rsp_valid, rsp_rdata and rsp_err from flops.
REQ-031 Zero-wait latency: accept at edge N gives SETUP in cycle N+1, ACCESS in cycle N+2, and rsp_valid plus cmd_ready=1 in cycle N+3.
REQ-032 SHALL NOT take back-to-back transfers: at least one IDLE cycle separates transfers, so the next accept is at the earliest at edge N+3.
REQ-033 SHALL give rsp_valid no backpressure; the requester must consume the pulse.
REQ-034 SHALL ignore cmd_valid outside IDLE; an unaccepted command has no effect.

Reset
REQ-035 PRESETn low SHALL immediately force, without waiting for a clock edge:
- state IDLE and counter 0;
- PSEL, PENABLE, PWRITE, PADDR and PWDATA all 0;
- rsp_valid, rsp_rdata and rsp_err all 0.
REQ-036 Reset asserted mid-transfer SHALL drop PSEL and PENABLE asynchronously and produce no rsp_valid for the aborted transfer.
REQ-037 cmd_ready SHALL be 1 during reset (state IDLE); no command is accepted while PRESETn is low.

Verification
REQ-038 Zero-wait write: write addr 0x3, data 0xA5, PREADY=1 -> SETUP then ACCESS with PADDR=3, PWDATA=A5, PWRITE=1; rsp_valid 3 cycles after accept; rsp_err=0; rsp_rdata=0.
REQ-039 Read with 2 wait states: read addr 0x6, PREADY low for 2 ACCESS cycles, PRDATA=0x5C -> 3 ACCESS cycles; rsp_rdata=0x5C; rsp_err=0.
REQ-040 Slave error: read with PREADY=1 and PSLVERR=1 -> rsp_valid=1 with rsp_err=1.
REQ-041 Timeout: PREADY held 0 with TIMEOUT=15 -> 16 ACCESS cycles, then IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-042 Busy and back-to-back: cmd_valid held high continuously -> cmd_ready=0 during SETUP and ACCESS; accepts spaced at least 3 cycles apart; PADDR stable for each transfer.
REQ-043 Mid-transfer reset: PRESETn pulsed low during ACCESS -> PSEL and PENABLE go 0 without a clock edge; no rsp_valid; after release, cmd_ready=1 and a new transfer completes normally.
